// File: rtl/sparse_enc_pkg.sv
// sparse_enc_pkg: shared FSM encoding and chunk-geometry helpers for the sparse chunk encoder. Rev 1.0
`default_nettype none

package sparse_enc_pkg;

  localparam int DEF_BUS_SIZE = 16;
  localparam int DEF_MEM_SIZE = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    STALL = 2'd2
  } enc_state_e;

  function automatic int wr_cyc_num(input int bus_size, input int mem_size);
    return mem_size / bus_size;
  endfunction

  // A single-beat chunk still needs a 1-bit counter port.
  function automatic int cnt_width(input int bus_size, input int mem_size);
    return (mem_size / bus_size > 1) ? $clog2(mem_size / bus_size) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sparse_beat_packer.sv
// sparse_beat_packer: zero-detect and left-pack of one dense beat (popcount port with ENC_NZ_COUNT_EN). Rev 1.0
`default_nettype none

module sparse_beat_packer #(
  parameter int BUS_SIZE = 16
) (
  input  logic [BUS_SIZE*8-1:0]         dense,
  output logic [BUS_SIZE-1:0]           sparsemap,
  output logic [BUS_SIZE*8-1:0]         packed_data
`ifdef ENC_NZ_COUNT_EN
  ,
  output logic [$clog2(BUS_SIZE+1)-1:0] nz_count
`endif
);

  localparam int PW = $clog2(BUS_SIZE + 1);

  logic [PW-1:0] pos;

  // pos is the running prefix count of nonzero lanes, i.e. the next free output lane.
  always_comb begin
    sparsemap   = '0;
    packed_data = '0;
    pos         = '0;
    for (int i = 0; i < BUS_SIZE; i++) begin
      if (dense[i*8 +: 8] != 8'h00) begin
        sparsemap[i]                  = 1'b1;
        packed_data[int'(pos)*8 +: 8] = dense[i*8 +: 8];
        pos                           = pos + 1'b1;
      end
    end
  end

`ifdef ENC_NZ_COUNT_EN
  assign nz_count = pos;
`endif

endmodule

`default_nettype wire

// File: rtl/sparse_chunk_encoder.sv
// sparse_chunk_encoder: zero-compresses dense beats into ping-pong sparse chunk buffers.
// Define ENC_NZ_COUNT_EN to add the per-chunk nonzero byte total nz_count_o. Rev 1.0
`default_nettype none

module sparse_chunk_encoder
  import sparse_enc_pkg::*;
#(
  parameter int BUS_SIZE = DEF_BUS_SIZE,
  parameter int MEM_SIZE = DEF_MEM_SIZE
) (
  input  logic                                          clk_i,
  input  logic                                          rst_i,
  input  logic                                          start_i,
  input  logic [BUS_SIZE*8-1:0]                         dense_data_i,
  input  logic                                          dense_valid_i,
  output logic                                          dense_ready_o,
  input  logic                                          rd_done_i,
  output logic [BUS_SIZE-1:0]                           wr_sparsemap_o,
  output logic [BUS_SIZE*8-1:0]                         wr_nonzero_data_o,
  output logic                                          wr_valid_o,
  output logic [cnt_width(BUS_SIZE, MEM_SIZE)-1:0]      wr_count_o,
  output logic                                          wr_sel_o,
  output logic                                          chunk_done_o,
`ifdef ENC_NZ_COUNT_EN
  output logic [$clog2(MEM_SIZE):0]                     nz_count_o,
`endif
  output logic [1:0]                                    buf_full_o
);

  localparam int WR_DAT_CYC_NUM     = wr_cyc_num(BUS_SIZE, MEM_SIZE);
  localparam int CW                 = cnt_width(BUS_SIZE, MEM_SIZE);
  localparam logic [CW-1:0] LAST_CNT = CW'(WR_DAT_CYC_NUM - 1);

  enc_state_e           state, state_nxt;
  logic [CW-1:0]        count;
  logic                 fill_sel;
  logic                 rd_ptr;
  logic [1:0]           buf_full, buf_full_nxt;
  logic                 accept, last_beat, rd_clr;
  logic [BUS_SIZE-1:0]  beat_map;
  logic [BUS_SIZE*8-1:0] beat_data;

`ifdef ENC_NZ_COUNT_EN
  localparam int NW = $clog2(MEM_SIZE) + 1;
  logic [$clog2(BUS_SIZE+1)-1:0] beat_nz;
`endif

  sparse_beat_packer #(
    .BUS_SIZE (BUS_SIZE)
  ) u_packer (
    .dense       (dense_data_i),
    .sparsemap   (beat_map),
    .packed_data (beat_data)
`ifdef ENC_NZ_COUNT_EN
    ,
    .nz_count    (beat_nz)
`endif
  );

  assign dense_ready_o = (state == FILL) && !buf_full[fill_sel];
  assign accept        = dense_valid_i && dense_ready_o;
  assign last_beat     = (count == LAST_CNT);
  assign rd_clr        = rd_done_i && buf_full[rd_ptr];
  assign buf_full_o    = buf_full;

  // Release and fill always target different buffers, so both updates can land together.
  always_comb begin
    state_nxt    = state;
    buf_full_nxt = buf_full;
    if (rd_clr)
      buf_full_nxt[rd_ptr] = 1'b0;
    if (accept && last_beat)
      buf_full_nxt[fill_sel] = 1'b1;
    case (state)
      IDLE:    if (start_i) state_nxt = FILL;
      FILL:    if (accept && last_beat && buf_full_nxt[~fill_sel]) state_nxt = STALL;
      STALL:   if (!buf_full[fill_sel]) state_nxt = FILL;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state             <= IDLE;
      count             <= '0;
      fill_sel          <= 1'b0;
      rd_ptr            <= 1'b0;
      buf_full          <= 2'b00;
      wr_valid_o        <= 1'b0;
      wr_sparsemap_o    <= '0;
      wr_nonzero_data_o <= '0;
      wr_count_o        <= '0;
      wr_sel_o          <= 1'b0;
      chunk_done_o      <= 1'b0;
    end else begin
      state          <= state_nxt;
      buf_full       <= buf_full_nxt;
      wr_valid_o     <= accept;
      chunk_done_o   <= accept && last_beat;
      if (rd_clr)
        rd_ptr <= ~rd_ptr;
      if (accept) begin
        count             <= last_beat ? '0 : count + 1'b1;
        fill_sel          <= last_beat ? ~fill_sel : fill_sel;
        wr_sparsemap_o    <= beat_map;
        wr_nonzero_data_o <= beat_data;
        wr_count_o        <= count;
        wr_sel_o          <= fill_sel;
      end else begin
        wr_sparsemap_o    <= '0;
        wr_nonzero_data_o <= '0;
        wr_count_o        <= '0;
        wr_sel_o          <= 1'b0;
      end
    end
  end

`ifdef ENC_NZ_COUNT_EN
  // First beat of a chunk restarts the running total.
  always_ff @(posedge clk_i) begin
    if (!rst_i)
      nz_count_o <= '0;
    else if (accept)
      nz_count_o <= (count == '0) ? NW'(beat_nz) : nz_count_o + NW'(beat_nz);
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_sparse_chunk_encoder.sv
// tb_sparse_chunk_encoder: directed self-checking bench, BUS_SIZE=8, MEM_SIZE=32 (4 beats per chunk).
`default_nettype none
`timescale 1ns/1ps

module tb_sparse_chunk_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [63:0] dense = '0;
  logic        dvalid = 1'b0;
  logic        dready;
  logic        rd_done = 1'b0;
  logic [7:0]  smap;
  logic [63:0] nzdata;
  logic        wvalid;
  logic [1:0]  wcount;
  logic        wsel;
  logic        cdone;
  logic [1:0]  bfull;
`ifdef ENC_NZ_COUNT_EN
  logic [5:0]  nzcnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sparse_chunk_encoder #(
    .BUS_SIZE (8),
    .MEM_SIZE (32)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .start_i           (start),
    .dense_data_i      (dense),
    .dense_valid_i     (dvalid),
    .dense_ready_o     (dready),
    .rd_done_i         (rd_done),
    .wr_sparsemap_o    (smap),
    .wr_nonzero_data_o (nzdata),
    .wr_valid_o        (wvalid),
    .wr_count_o        (wcount),
    .wr_sel_o          (wsel),
    .chunk_done_o      (cdone),
`ifdef ENC_NZ_COUNT_EN
    .nz_count_o        (nzcnt),
`endif
    .buf_full_o        (bfull)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; start = 1'b0; dvalid = 1'b0; rd_done = 1'b0; dense = '0;
    tick(); tick();
    rst = 1'b1;
  endtask

  task automatic arm();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; dvalid = 1'b0; rd_done = 1'b0; dense = '0;
    tick(); tick();
    n_tests++; if ({wvalid, cdone, wsel, wcount} !== 5'b0) begin n_fail++; $display("FAIL reset_ctrl: got %b required 00000", {wvalid, cdone, wsel, wcount}); end
    n_tests++; if ({smap, nzdata} !== 72'h0) begin n_fail++; $display("FAIL reset_data: got %h required 0", {smap, nzdata}); end
    n_tests++; if ({dready, bfull} !== 3'b000) begin n_fail++; $display("FAIL reset_ready_full: got %b required 000", {dready, bfull}); end
    rst = 1'b1;
    tick();
    n_tests++; if (dready !== 1'b0) begin n_fail++; $display("FAIL idle_ready: got %b required 0", dready); end
  endtask

  task automatic test_basic_beat();
    do_reset();
    arm();
    n_tests++; if (dready !== 1'b1) begin n_fail++; $display("FAIL fill_ready: got %b required 1", dready); end
    dense = 64'h0900_0007_0000_0500;
    dvalid = 1'b1;
    n_tests++; if (wvalid !== 1'b0) begin n_fail++; $display("FAIL basic_pre_valid: got %b required 0", wvalid); end
    tick();
    dvalid = 1'b0;
    n_tests++; if (wvalid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b required 1", wvalid); end
    n_tests++; if (smap !== 8'b1001_0010) begin n_fail++; $display("FAIL basic_map: got %b required 10010010", smap); end
    n_tests++; if (nzdata !== 64'h0000_0000_0009_0705) begin n_fail++; $display("FAIL basic_data: got %h required 0000000000090705", nzdata); end
    n_tests++; if ({wcount, wsel, cdone} !== 4'b0000) begin n_fail++; $display("FAIL basic_cnt_sel: got %b required 0000", {wcount, wsel, cdone}); end
    tick();
    n_tests++; if (wvalid !== 1'b0) begin n_fail++; $display("FAIL basic_single_pulse: got %b required 0", wvalid); end
  endtask

  task automatic test_zero_chunk();
    do_reset();
    arm();
    dense = '0;
    for (int i = 0; i < 4; i++) begin
      dvalid = 1'b1;
      tick();
      n_tests++; if ({wvalid, smap, nzdata} !== {1'b1, 72'h0}) begin n_fail++; $display("FAIL zero_beat%0d: got v=%b map=%h data=%h required v=1 map=0 data=0", i, wvalid, smap, nzdata); end
      n_tests++; if ({wcount, cdone} !== {2'(i), (i == 3)}) begin n_fail++; $display("FAIL zero_cnt%0d: got cnt=%0d done=%b required cnt=%0d done=%b", i, wcount, cdone, i, (i == 3)); end
    end
    n_tests++; if (bfull !== 2'b01) begin n_fail++; $display("FAIL zero_full: got %b required 01", bfull); end
    tick();
    n_tests++; if ({wvalid, wsel, wcount} !== 4'b1100) begin n_fail++; $display("FAIL zero_next_sel: got v/sel/cnt %b required 1100", {wvalid, wsel, wcount}); end
    dvalid = 1'b0;
  endtask

  task automatic test_stall();
    do_reset();
    arm();
    dense = 64'h1111_1111_1111_1111;
    dvalid = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    n_tests++; if ({cdone, wsel, wcount} !== 4'b1111) begin n_fail++; $display("FAIL stall_last: got done/sel/cnt %b required 1111", {cdone, wsel, wcount}); end
    n_tests++; if ({bfull, dready} !== 3'b110) begin n_fail++; $display("FAIL stall_full: got full/ready %b required 110", {bfull, dready}); end
    tick();
    n_tests++; if (wvalid !== 1'b0) begin n_fail++; $display("FAIL stall_hold: got %b required 0", wvalid); end
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    n_tests++; if ({bfull, dready, wvalid} !== 4'b1000) begin n_fail++; $display("FAIL stall_release: got full/ready/v %b required 1000", {bfull, dready, wvalid}); end
    tick();
    n_tests++; if ({dready, wvalid} !== 2'b10) begin n_fail++; $display("FAIL stall_resume: got ready/v %b required 10", {dready, wvalid}); end
    tick();
    dvalid = 1'b0;
    n_tests++; if ({wvalid, wsel, wcount} !== 4'b1000) begin n_fail++; $display("FAIL stall_next: got v/sel/cnt %b required 1000", {wvalid, wsel, wcount}); end
  endtask

  task automatic test_gaps();
    logic [3:0] pat;
    int         exp_cnt;
    pat = 4'b1001;
    exp_cnt = 0;
    do_reset();
    arm();
    dense = 64'h0102_0304_0506_0708;
    for (int i = 0; i < 4; i++) begin
      dvalid = pat[i];
      tick();
      n_tests++; if (wvalid !== pat[i]) begin n_fail++; $display("FAIL gap_valid%0d: got %b required %b", i, wvalid, pat[i]); end
      if (pat[i]) begin
        n_tests++; if ({wcount, smap, nzdata} !== {2'(exp_cnt), 8'hFF, 64'h0102_0304_0506_0708}) begin n_fail++; $display("FAIL gap_beat%0d: got cnt=%0d map=%h data=%h required cnt=%0d map=ff data=0102030405060708", i, wcount, smap, nzdata, exp_cnt); end
        exp_cnt++;
      end
    end
    dvalid = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    arm();
    dense = 64'h0000_0000_0000_0042;
    dvalid = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    rst = 1'b0;
    tick();
    n_tests++; if ({wvalid, cdone, wsel, wcount, smap, nzdata, bfull, dready} !== 80'h0) begin n_fail++; $display("FAIL midrst_outputs: got v=%b full=%b ready=%b cnt=%0d sel=%b required all 0", wvalid, bfull, dready, wcount, wsel); end
    rst = 1'b1;
    dvalid = 1'b0;
    arm();
    dvalid = 1'b1;
    tick();
    dvalid = 1'b0;
    n_tests++; if ({wvalid, wcount, wsel, smap} !== {1'b1, 2'b00, 1'b0, 8'h01}) begin n_fail++; $display("FAIL midrst_restart: got v=%b cnt=%0d sel=%b map=%h required v=1 cnt=0 sel=0 map=01", wvalid, wcount, wsel, smap); end
  endtask

`ifdef ENC_NZ_COUNT_EN
  task automatic test_nz_count();
    logic [63:0] beats [4];
    int          totals [4];
    beats[0] = 64'h0000_0000_0001_0203; totals[0] = 3;
    beats[1] = 64'h0102_0304_0506_0708; totals[1] = 11;
    beats[2] = 64'h0000_0000_0000_0000; totals[2] = 11;
    beats[3] = 64'h8000_0000_0000_0000; totals[3] = 12;
    do_reset();
    arm();
    for (int i = 0; i < 4; i++) begin
      dense = beats[i];
      dvalid = 1'b1;
      tick();
      n_tests++; if ({nzcnt, cdone} !== {6'(totals[i]), (i == 3)}) begin n_fail++; $display("FAIL nz_count%0d: got nz=%0d done=%b required nz=%0d done=%b", i, nzcnt, cdone, totals[i], (i == 3)); end
    end
    dvalid = 1'b0;
    n_tests++; if (nzdata !== 64'h0000_0000_0000_0080) begin n_fail++; $display("FAIL nz_pack_lane7: got %h required 0000000000000080", nzdata); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_beat();
    test_zero_chunk();
    test_stall();
    test_gaps();
    test_reset_mid();
`ifdef ENC_NZ_COUNT_EN
    test_nz_count();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
